// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one 8Kx8 screen RAM between priority video fetch (fixed 2-cycle latency, vid_valid/vid_miss) and a stallable Z80 port (cpu_req/ack/wait) driving registered ram_* outputs
module vram_arbiter #(
  parameter int AW = 13,
  parameter int DW = 8,
  parameter int MAX_WAIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  output logic          vid_miss,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_wait,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUED, DATA} cpu_state_t;
  localparam logic [7:0] MW = 8'(MAX_WAIT);
  cpu_state_t state;
  logic [7:0] wait_cnt;
  logic cpu_idle, force_cpu, vid_grant, cpu_grant, s1_valid, s1_miss, cpu_wr;
  assign cpu_idle = state == IDLE;
  assign force_cpu = (wait_cnt == MW) & cpu_req & cpu_idle;
  assign vid_grant = vid_req & ~force_cpu;
  assign cpu_grant = ~vid_grant & cpu_idle & cpu_req;
  assign cpu_wait = cpu_req & ~cpu_ack & ~reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      ram_addr <= '0;
      ram_we <= 1'b0;
      ram_wdata <= '0;
      cpu_wr <= 1'b0;
      cpu_ack <= 1'b0;
      cpu_rdata <= '0;
      s1_valid <= 1'b0;
      s1_miss <= 1'b0;
      vid_valid <= 1'b0;
      vid_miss <= 1'b0;
      vid_data <= '0;
    end else begin
      ram_we <= cpu_grant & cpu_we;
      ram_addr <= vid_grant ? vid_addr : cpu_grant ? cpu_addr : ram_addr;
      if (cpu_grant) begin
        ram_wdata <= cpu_wdata;
        cpu_wr <= cpu_we;
      end
      wait_cnt <= (~cpu_req | cpu_grant) ? 8'd0 :
                  (cpu_idle & vid_grant & (wait_cnt != MW)) ? wait_cnt + 8'd1 : wait_cnt;
      state <= cpu_grant ? ISSUED : (state == ISSUED) ? DATA : IDLE;
      cpu_ack <= state == ISSUED;
      if (state == ISSUED && !cpu_wr) cpu_rdata <= ram_rdata;
      s1_valid <= vid_grant;
      s1_miss <= vid_req & force_cpu;
      vid_valid <= s1_valid;
      vid_miss <= s1_miss;
      if (s1_valid) vid_data <= ram_rdata;
    end
  end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed self-checking bench for vram_arbiter with a behavioural screen RAM
module tb_vram_arbiter;
  logic clk = 0, reset = 1;
  logic vid_req = 0, cpu_req = 0, cpu_we = 0;
  logic [12:0] vid_addr = 0, cpu_addr = 0;
  logic [7:0] cpu_wdata = 0;
  logic [7:0] vid_data, cpu_rdata, ram_wdata, ram_rdata;
  logic vid_valid, vid_miss, cpu_ack, cpu_wait, ram_we;
  logic [12:0] ram_addr;
  logic [7:0] mem [0:8191];
  int total = 0, bad = 0;

  vram_arbiter dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .vid_valid(vid_valid), .vid_miss(vid_miss),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  initial for (int i = 0; i < 8192; i++) mem[i] = 8'(i);

  task automatic do_reset();
    @(negedge clk);
    reset = 1; vid_req = 0; cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_reset();
    vid_req = 1; cpu_req = 1; vid_addr = 13'h0005; cpu_addr = 13'h0009;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); reset = 1; #1;
      if (c > 0) begin
        total++;
        if ({vid_valid, vid_miss, cpu_ack, ram_we, cpu_wait} !== 5'b0 || ram_addr !== 13'h0 ||
            vid_data !== 8'h0 || cpu_rdata !== 8'h0 || ram_wdata !== 8'h0) begin
          bad++;
          $display("FAIL reset_outputs c=%0d got v=%b m=%b a=%b we=%b w=%b addr=%h vd=%h rd=%h wd=%h want all 0",
                   c, vid_valid, vid_miss, cpu_ack, ram_we, cpu_wait, ram_addr, vid_data, cpu_rdata, ram_wdata);
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); reset = 0; #1;
      total++;
      if (vid_valid !== (c == 2)) begin
        bad++; $display("FAIL reset_first_valid c=%0d got %b want %b", c, vid_valid, c == 2);
      end
    end
    total++;
    if (vid_data !== 8'h05) begin bad++; $display("FAIL reset_first_data got %h want 05", vid_data); end
    do_reset();
  endtask

  task automatic test_cpu_write_read();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cpu_req = c < 3; cpu_we = 1; cpu_addr = 13'h1ABC; cpu_wdata = (c == 0) ? 8'h5A : 8'hFF; #1;
      total++;
      if (cpu_wait !== (c < 2)) begin bad++; $display("FAIL wr_wait c=%0d got %b want %b", c, cpu_wait, c < 2); end
      total++;
      if (cpu_ack !== (c == 2)) begin bad++; $display("FAIL wr_ack c=%0d got %b want %b", c, cpu_ack, c == 2); end
      total++;
      if (ram_we !== (c == 1)) begin bad++; $display("FAIL wr_ram_we c=%0d got %b want %b", c, ram_we, c == 1); end
      if (c == 1) begin
        total++;
        if (ram_addr !== 13'h1ABC || ram_wdata !== 8'h5A) begin
          bad++; $display("FAIL wr_ram_bus got addr=%h data=%h want 1abc 5a", ram_addr, ram_wdata);
        end
      end
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cpu_req = c < 3; cpu_we = 0; cpu_addr = (c == 0) ? 13'h1ABC : 13'h0000; #1;
      total++;
      if (cpu_ack !== (c == 2)) begin bad++; $display("FAIL rd_ack c=%0d got %b want %b", c, cpu_ack, c == 2); end
      if (c == 2) begin
        total++;
        if (cpu_rdata !== 8'h5A) begin bad++; $display("FAIL rd_data got %h want 5a", cpu_rdata); end
      end
    end
  endtask

  task automatic test_video_stream();
    do_reset();
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      vid_req = c < 16; vid_addr = 13'(c); #1;
      total++;
      if (vid_valid !== (c >= 2 && c < 18) || vid_miss !== 1'b0) begin
        bad++; $display("FAIL stream_valid c=%0d got v=%b m=%b want v=%b m=0", c, vid_valid, vid_miss, c >= 2 && c < 18);
      end
      if (c >= 2 && c < 18) begin
        total++;
        if (vid_data !== 8'(c - 2)) begin bad++; $display("FAIL stream_data c=%0d got %h want %h", c, vid_data, 8'(c - 2)); end
      end
    end
  endtask

  task automatic test_starvation();
    logic [7:0] exp_vd;
    do_reset();
    exp_vd = 8'h00;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      vid_req = 1; vid_addr = 13'(8'h20 + c);
      cpu_req = c >= 10 && c <= 20; cpu_we = 0; cpu_addr = 13'h0133; #1;
      if (c >= 2 && c != 20) exp_vd = 8'(8'h20 + c - 2);
      total++;
      if (vid_valid !== (c >= 2 && c != 20) || vid_miss !== (c == 20)) begin
        bad++; $display("FAIL starve_tags c=%0d got v=%b m=%b want v=%b m=%b", c, vid_valid, vid_miss, c >= 2 && c != 20, c == 20);
      end
      total++;
      if (vid_data !== exp_vd) begin bad++; $display("FAIL starve_vdata c=%0d got %h want %h", c, vid_data, exp_vd); end
      total++;
      if (cpu_ack !== (c == 20)) begin bad++; $display("FAIL starve_ack c=%0d got %b want %b", c, cpu_ack, c == 20); end
      if (c >= 10 && c <= 19) begin
        total++;
        if (cpu_wait !== 1'b1) begin bad++; $display("FAIL starve_wait c=%0d got %b want 1", c, cpu_wait); end
      end
      if (c == 19) begin
        total++;
        if (ram_addr !== 13'h0133) begin bad++; $display("FAIL starve_ram_addr got %h want 0133", ram_addr); end
      end
      if (c == 20) begin
        total++;
        if (cpu_rdata !== 8'h33) begin bad++; $display("FAIL starve_rdata got %h want 33", cpu_rdata); end
      end
    end
    vid_req = 0; cpu_req = 0;
  endtask

  task automatic test_reset_issued();
    do_reset();
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'h0200; cpu_wdata = 8'hAA;
    @(negedge clk);
    reset = 1; #1;
    total++;
    if (ram_we !== 1'b1) begin bad++; $display("FAIL issued_we_before got %b want 1", ram_we); end
    @(negedge clk);
    reset = 0; cpu_req = 0; #1;
    total++;
    if (ram_we !== 1'b0 || cpu_ack !== 1'b0) begin
      bad++; $display("FAIL issued_reset got we=%b ack=%b want 0 0", ram_we, cpu_ack);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cpu_req = c < 3; cpu_we = 0; cpu_addr = 13'h0005; #1;
      total++;
      if (cpu_ack !== (c == 2)) begin bad++; $display("FAIL issued_after_ack c=%0d got %b want %b", c, cpu_ack, c == 2); end
    end
    total++;
    if (cpu_rdata !== 8'h05) begin bad++; $display("FAIL issued_after_rdata got %h want 05", cpu_rdata); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vid_req = 1; vid_addr = 13'h0040; cpu_req = c < 11; cpu_addr = 13'h0006; #1;
      total++;
      if (cpu_ack !== (c == 10)) begin bad++; $display("FAIL issued_force_ack c=%0d got %b want %b", c, cpu_ack, c == 10); end
    end
    vid_req = 0; cpu_req = 0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      cpu_req = c < 10; cpu_we = 0; cpu_addr = 13'h0007; #1;
      total++;
      if (cpu_ack !== (c % 3 == 2)) begin bad++; $display("FAIL b2b_ack c=%0d got %b want %b", c, cpu_ack, c % 3 == 2); end
      if (c % 3 == 2) begin
        total++;
        if (cpu_rdata !== 8'h07) begin bad++; $display("FAIL b2b_rdata c=%0d got %h want 07", c, cpu_rdata); end
      end
      if (c % 3 == 1) begin
        total++;
        if (ram_addr !== 13'h0007 || ram_we !== 1'b0) begin
          bad++; $display("FAIL b2b_ram c=%0d got addr=%h we=%b want 0007 0", c, ram_addr, ram_we);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    test_video_stream();
    test_starvation();
    test_reset_issued();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
